tx_fifo_ptr_ctrl: RTL and testbench

Storage and pointer-management core of the transmit FIFO, directly upstream of the FIFO's full/empty status logic.
- Accepts 32-bit words from the bus-side writer.
- Serves single bytes, least-significant byte first, to the serial transmit side.
- Maintains the head/tail pointers, wrap toggles and intra-word byte index that the status logic consumes.
- Also drives its own registered-state-derived full, empty and occupancy outputs.

---
 rtl/tx_fifo_ptr_ctrl.sv | 105 ++++++++++
 tb/tb_tx_fifo_ptr_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_fifo_ptr_ctrl.sv
// Transmit FIFO storage and pointer core.
// Words are written whole on the bus side and drained one byte at a time,
// least-significant byte first. Head/tail pointers carry a wrap toggle so the
// status logic can tell full from empty when the pointers coincide.
module tx_fifo_ptr_ctrl #(
   parameter  int DEPTH          = 8,
   parameter  int BYTES_PER_WORD = 4,
   localparam int PW             = $clog2(DEPTH),
   localparam int SW             = $clog2(BYTES_PER_WORD),
   localparam int DW             = 8 * BYTES_PER_WORD,
   localparam int CW             = PW + SW + 1
) (
   input  logic          clk,
   input  logic          n_rst,
   input  logic          clear,
   input  logic          write_en,
   input  logic [DW-1:0] write_data,
   input  logic          read_en,
   output logic [7:0]    read_data,
   output logic [PW-1:0] head_ptr,
   output logic [SW-1:0] head_side,
   output logic [PW-1:0] tail_ptr,
   output logic          head_tog,
   output logic          tail_tog,
   output logic          full,
   output logic          empty,
   output logic [CW-1:0] byte_count,
   output logic          overrun,
   output logic          underrun
);

   logic [DEPTH-1:0][DW-1:0] mem;
   logic [DW-1:0]            head_word;
   logic [PW:0]              words;
   logic [CW-1:0]            word_bytes;
   logic                     ptr_eq;
   logic                     wr_acc;
   logic                     rd_acc;
   logic                     last_side;

   // Status is derived from registered pointers only, never from this
   // cycle's requests, so full/empty are stable for the whole cycle.
   assign ptr_eq     = (head_ptr == tail_ptr);
   assign empty      = ptr_eq && (head_tog == tail_tog) && (head_side == '0);
   assign full       = ptr_eq && (head_tog != tail_tog);
   assign words      = {tail_tog, tail_ptr} - {head_tog, head_ptr};
   assign word_bytes = {words, {SW{1'b0}}};
   assign byte_count = word_bytes - CW'(head_side);

   // Both requests are judged against the pre-edge status: a read that frees
   // the last slot of a full FIFO still does not admit a same-cycle write.
   assign wr_acc     = write_en && !full;
   assign rd_acc     = read_en && !empty;
   assign last_side  = (head_side == SW'(BYTES_PER_WORD - 1));

   // Show-ahead byte select from the head word.
   assign head_word  = mem[head_ptr];
   assign read_data  = head_word[{head_side, 3'b000} +: 8];

   // Word storage; clear flushes pointers only and leaves contents intact.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         mem <= '0;
      end else if (!clear && wr_acc) begin
         mem[tail_ptr] <= write_data;
      end
   end

   // Pointer, toggle, byte-index and error-pulse state.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         head_ptr  <= '0;
         head_side <= '0;
         head_tog  <= 1'b0;
         tail_ptr  <= '0;
         tail_tog  <= 1'b0;
         overrun   <= 1'b0;
         underrun  <= 1'b0;
      end else if (clear) begin
         head_ptr  <= '0;
         head_side <= '0;
         head_tog  <= 1'b0;
         tail_ptr  <= '0;
         tail_tog  <= 1'b0;
         overrun   <= 1'b0;
         underrun  <= 1'b0;
      end else begin
         overrun  <= write_en && full;
         underrun <= read_en && empty;
         if (wr_acc) begin
            {tail_tog, tail_ptr} <= {tail_tog, tail_ptr} + (PW + 1)'(1);
         end
         if (rd_acc) begin
            if (last_side) begin
               // Slot is released only once its final byte is consumed.
               head_side            <= '0;
               {head_tog, head_ptr} <= {head_tog, head_ptr} + (PW + 1)'(1);
            end else begin
               head_side <= head_side + SW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_tx_fifo_ptr_ctrl.sv
// Self-checking bench for tx_fifo_ptr_ctrl: a queue-of-words reference model
// is compared against the DUT every cycle, plus directed literal checks.
module tb_tx_fifo_ptr_ctrl;

   logic        clk;
   logic        n_rst;
   logic        clear;
   logic        write_en;
   logic [31:0] write_data;
   logic        read_en;
   logic [7:0]  read_data;
   logic [2:0]  head_ptr;
   logic [1:0]  head_side;
   logic [2:0]  tail_ptr;
   logic        head_tog;
   logic        tail_tog;
   logic        full;
   logic        empty;
   logic [5:0]  byte_count;
   logic        overrun;
   logic        underrun;

   int tests = 0;
   int fails = 0;

   tx_fifo_ptr_ctrl dut (
      .clk        (clk),
      .n_rst      (n_rst),
      .clear      (clear),
      .write_en   (write_en),
      .write_data (write_data),
      .read_en    (read_en),
      .read_data  (read_data),
      .head_ptr   (head_ptr),
      .head_side  (head_side),
      .tail_ptr   (tail_ptr),
      .head_tog   (head_tog),
      .tail_tog   (tail_tog),
      .full       (full),
      .empty      (empty),
      .byte_count (byte_count),
      .overrun    (overrun),
      .underrun   (underrun)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   // Reference model: FIFO contents as a queue of words, the byte offset into
   // the front word, and running totals of words pushed / fully popped.
   logic [31:0] mq[$];
   int          m_side;
   int          m_pops;
   int          m_pushes;
   bit          m_ov;
   bit          m_un;
   bit          mf;
   bit          me;

   task automatic mreset();
      mq.delete();
      m_side   = 0;
      m_pops   = 0;
      m_pushes = 0;
      m_ov     = 1'b0;
      m_un     = 1'b0;
   endtask

   always @(posedge clk or negedge n_rst) begin
      if (!n_rst || clear) begin
         mreset();
      end else begin
         mf   = (mq.size() == 8);
         me   = (mq.size() == 0);
         m_ov = write_en && mf;
         m_un = read_en && me;
         if (read_en && !me) begin
            m_side++;
            if (m_side == 4) begin
               m_side = 0;
               void'(mq.pop_front());
               m_pops++;
            end
         end
         if (write_en && !mf) begin
            mq.push_back(write_data);
            m_pushes++;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Per-cycle comparison against the model, after both have settled.
   always begin
      @(posedge clk);
      #2;
      check("m_empty", 32'(empty), 32'(mq.size() == 0));
      check("m_full", 32'(full), 32'(mq.size() == 8));
      check("m_byte_count", 32'(byte_count), 32'(4 * mq.size() - m_side));
      check("m_head_ptr", 32'(head_ptr), 32'(m_pops % 8));
      check("m_head_tog", 32'(head_tog), 32'((m_pops / 8) % 2));
      check("m_head_side", 32'(head_side), 32'(m_side));
      check("m_tail_ptr", 32'(tail_ptr), 32'(m_pushes % 8));
      check("m_tail_tog", 32'(tail_tog), 32'((m_pushes / 8) % 2));
      check("m_overrun", 32'(overrun), 32'(m_ov));
      check("m_underrun", 32'(underrun), 32'(m_un));
      if (mq.size() != 0) check("m_read_data", 32'(read_data), 32'(mq[0][8*m_side +: 8]));
   end

   // One stimulus cycle; returns shortly after the edge with outputs settled.
   task automatic cyc(input bit we, input logic [31:0] wd, input bit re, input bit clr);
      @(negedge clk);
      write_en   = we;
      write_data = wd;
      read_en    = re;
      clear      = clr;
      @(posedge clk);
      #3;
   endtask

   task automatic do_reset();
      @(negedge clk);
      n_rst = 1'b0;
      write_en = 1'b0; read_en = 1'b0; clear = 1'b0; write_data = '0;
      @(negedge clk);
      n_rst = 1'b1;
   endtask

   int guard;

   initial begin
      n_rst = 1'b0; clear = 1'b0; write_en = 1'b0; read_en = 1'b0; write_data = '0;
      repeat (2) @(negedge clk);
      n_rst = 1'b1;
      #1;
      // 1: reset state, first word and byte order
      check("rst_empty", 32'(empty), 32'd1);
      check("rst_full", 32'(full), 32'd0);
      check("rst_count", 32'(byte_count), 32'd0);
      check("rst_rdata", 32'(read_data), 32'd0);
      cyc(1, 32'hDDCCBBAA, 0, 0);
      check("t1_empty", 32'(empty), 32'd0);
      check("t1_count", 32'(byte_count), 32'd4);
      check("t1_b0", 32'(read_data), 32'hAA);
      cyc(0, 0, 1, 0); check("t1_b1", 32'(read_data), 32'hBB);
      cyc(0, 0, 1, 0); check("t1_b2", 32'(read_data), 32'hCC);
      cyc(0, 0, 1, 0); check("t1_b3", 32'(read_data), 32'hDD);
      cyc(0, 0, 1, 0);
      check("t1_empty_end", 32'(empty), 32'd1);
      check("t1_head_ptr", 32'(head_ptr), 32'd1);
      check("t1_head_side", 32'(head_side), 32'd0);

      // 2: fill to full, then overrun
      do_reset();
      for (int i = 0; i < 8; i++) cyc(1, 32'hA0B0C0D0 + 32'(i), 0, 0);
      check("t2_full", 32'(full), 32'd1);
      check("t2_tail_ptr", 32'(tail_ptr), 32'd0);
      check("t2_tail_tog", 32'(tail_tog), 32'd1);
      check("t2_count", 32'(byte_count), 32'd32);
      cyc(1, 32'hDEADBEEF, 0, 0);
      check("t2_overrun", 32'(overrun), 32'd1);
      check("t2_mem0", 32'(read_data), 32'hD0);
      cyc(0, 0, 0, 0);
      check("t2_overrun_pulse", 32'(overrun), 32'd0);

      // 3: full with head_side==3, simultaneous write+read
      cyc(0, 0, 1, 0); cyc(0, 0, 1, 0); cyc(0, 0, 1, 0);
      check("t3_side3", 32'(head_side), 32'd3);
      cyc(1, 32'h12345678, 1, 0);
      check("t3_overrun", 32'(overrun), 32'd1);
      check("t3_head_ptr", 32'(head_ptr), 32'd1);
      check("t3_full", 32'(full), 32'd0);
      check("t3_count", 32'(byte_count), 32'd28);

      // 4: underrun, then write+read while empty
      do_reset();
      cyc(0, 0, 1, 0);
      check("t4_underrun", 32'(underrun), 32'd1);
      check("t4_head_ptr", 32'(head_ptr), 32'd0);
      check("t4_side", 32'(head_side), 32'd0);
      cyc(0, 0, 0, 0);
      check("t4_underrun_pulse", 32'(underrun), 32'd0);
      cyc(1, 32'h0BADF00D, 1, 0);
      check("t4_count", 32'(byte_count), 32'd4);
      check("t4_underrun2", 32'(underrun), 32'd1);
      check("t4_rdata", 32'(read_data), 32'h0D);

      // 5: randomized stream of 20 words; both pointers wrap twice
      cyc(0, 0, 0, 1);
      guard = 0;
      while (m_pushes < 20 && guard < 2000) begin
         cyc(1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 3) != 0), 0);
         guard++;
      end
      check("t5_pushes", 32'(m_pushes), 32'd20);
      guard = 0;
      while (mq.size() != 0 && guard < 500) begin
         cyc(1'b0, 0, 1'b1, 0);
         guard++;
      end
      check("t5_drained", 32'(mq.size()), 32'd0);
      check("t5_head_ptr", 32'(head_ptr), 32'd4);
      check("t5_tail_ptr", 32'(tail_ptr), 32'd4);
      check("t5_head_tog", 32'(head_tog), 32'd0);
      check("t5_tail_tog", 32'(tail_tog), 32'd0);
      check("t5_empty", 32'(empty), 32'd1);

      // 6: clear mid-stream, then asynchronous reset mid-cycle
      cyc(0, 0, 0, 1);
      for (int i = 0; i < 4; i++) cyc(1, $urandom, 0, 0);
      for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0);
      check("t6_count13", 32'(byte_count), 32'd13);
      cyc(1, 32'hFFFF0000, 1, 1);
      check("t6_clr_head", 32'(head_ptr), 32'd0);
      check("t6_clr_tail", 32'(tail_ptr), 32'd0);
      check("t6_clr_side", 32'(head_side), 32'd0);
      check("t6_clr_togs", 32'({head_tog, tail_tog}), 32'd0);
      check("t6_clr_empty", 32'(empty), 32'd1);
      cyc(1, 32'h55667788, 0, 0);
      cyc(1, 32'h99AABBCC, 1, 0);
      cyc(0, 0, 0, 0);
      #1 n_rst = 1'b0;
      #2;
      check("t6_arst_side", 32'(head_side), 32'd0);
      check("t6_arst_tail", 32'(tail_ptr), 32'd0);
      check("t6_arst_empty", 32'(empty), 32'd1);
      check("t6_arst_count", 32'(byte_count), 32'd0);
      check("t6_arst_rdata", 32'(read_data), 32'd0);
      #2 n_rst = 1'b1;
      cyc(0, 0, 1, 0);
      check("t6_post_underrun", 32'(underrun), 32'd1);
      cyc(0, 0, 0, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
